// File: rtl/fpr_cdb_arbiter_pkg.sv
// Shared FP CDB definitions: broadcast record, ROB tag width and tag matching.
package fpr_cdb_arbiter_pkg;

  localparam int ROB_WIDTH = 6;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  function automatic logic tag_match(input cdb_t c, input logic [ROB_WIDTH-1:0] t);
    return c.valid && (c.tag == t);
  endfunction

endpackage

// File: rtl/fpr_cdb_arbiter_if.sv
// FP unit <-> CDB arbiter bundle: per-unit request/grant/payload, flush and the broadcast bus.
interface fpr_cdb_arbiter_if
  import fpr_cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  logic [N_REQ-1:0]                req_valid;
  logic [N_REQ-1:0]                req_ready;
  logic [N_REQ-1:0][ROB_WIDTH-1:0] req_tag;
  logic [N_REQ-1:0][31:0]          req_data;
  logic                            flush;
  cdb_t                            fpr_cdb;

  modport master (
    output req_valid, req_tag, req_data, flush,
    input  req_ready, fpr_cdb
  );

  modport slave (
    input  req_valid, req_tag, req_data, flush,
    output req_ready, fpr_cdb
  );

endinterface

// File: rtl/fpr_cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int PTR_W = $clog2(N);

  logic [2*N-1:0] dbl;

  // Scanning {req,req} from ptr covers the wrapped order without modulo on non-pow2 N.
  always_comb begin
    dbl   = {req, req};
    idx   = '0;
    any   = 1'b0;
    grant = '0;
    for (int unsigned j = 0; j < 2 * N; j++) begin
      if (!any && dbl[j] && (j >= 32'(ptr))) begin
        any = 1'b1;
        if (j >= N) idx = PTR_W'(j - N);
        else        idx = PTR_W'(j);
      end
    end
    if (any) grant = N'(1) << idx;
  end

endmodule

// File: rtl/fpr_cdb_arbiter.sv
// FP common data bus arbiter: round-robin grant among FP units, registered broadcast.
module fpr_cdb_arbiter
  import fpr_cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input logic              clk,
  input logic              reset,
  fpr_cdb_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] rr_ptr;
  logic [N_REQ-1:0] pick_grant;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic             do_grant;
  cdb_t             cdb_q;

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    do_grant      = pick_any && !bus.flush && !reset;
    bus.req_ready = do_grant ? pick_grant : '0;
    bus.fpr_cdb   = cdb_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_q  <= '0;
      rr_ptr <= '0;
    end else begin
      cdb_q.valid <= do_grant;
      if (do_grant) begin
        cdb_q.tag  <= bus.req_tag[pick_idx];
        cdb_q.data <= bus.req_data[pick_idx];
        rr_ptr     <= (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
      end
    end
  end

endmodule
